data_reader: RTL and testbench
==============================

// Module: data_reader
// PURPOSE
// - Drains result memories (accumulator/conv-unit banks) into an AXIS master stream.
// - Feeds the s_axis write path of axi_mst; it is the mirror of data_writer, which
//   turns the m_axis read stream into one-hot bank write enables.
// - On start it reads bank 0 words 0..len-1, then bank 1, and so on up to bank
//   N_BANK-1, emitting one beat per word.
// PARAMETERS
// - DATA_WIDTH  64  beat and memory word width, bits
// - N_BANK      64  number of result banks; must be >= 2
// - ADDR_WIDTH  10  word address width of each bank
// PORTS
// - clk            in   1                  single clock for all logic
// - rst            in   1                  asynchronous reset, active-high
// - start          in   1                  1-cycle pulse; sampled only in IDLE
// - len            in   ADDR_WIDTH+1       words per bank; latched on start
// - idle           out  1                  1 when in IDLE
// - mem_en         out  N_BANK             one-hot read enable, bank select
// - mem_addr       out  ADDR_WIDTH         word address, shared by all banks
// - mem_do         in   N_BANK*DATA_WIDTH  bank b data on [b*DATA_WIDTH +: DATA_WIDTH]
// - m_axis_tdata   out  DATA_WIDTH         stream data
// - m_axis_tstrb   out  DATA_WIDTH/8       constant all ones
// - m_axis_tlast   out  1                  1 on the final beat of the transfer only
// - m_axis_tvalid  out  1                  stream valid
// - m_axis_tready  in   1                  stream ready
// BEHAVIOUR
// Reset
// - idle=1, mem_en=0, mem_addr=0, tvalid=0, tlast=0, tdata=0.
// - FIFO flushed, counters cleared.
// - Reset mid-transfer abandons it. Beats not yet accepted are lost.
// Memory
// - Synchronous read, latency 1: data for an issue in cycle t is sampled from
//   mem_do in cycle t+1, using the bank index registered at issue.
// States
// - IDLE: start with len==0 -> DONE. start with len!=0 -> READ, with bank=0, addr=0.
// - READ: issue one read per cycle while (fifo_cnt + inflight - pop) < 2.
//   pop = tvalid & tready.
//   Step addr; on addr==len-1, wrap addr to 0 and increment bank.
//   After issuing (bank N_BANK-1, addr len-1) -> DRAIN.
// - DRAIN: no issues. When FIFO is empty and inflight==0 -> DONE.
// - DONE: one cycle, then IDLE. idle rises the cycle after DONE.
// Handshake
// - start is ignored outside IDLE.
// - Once tvalid rises, tdata/tlast stay stable until tready.
// - A beat transfers on tvalid & tready.
// Throughput
// - One beat per cycle when tready is held high.
// - First tvalid 2 cycles after start.
// FIFO
// - 2 entries of {tlast, tdata}.
// - Push and pop in the same cycle are allowed at any count. Never overflows.
// - tlast is tagged at issue of the final read.
// Widths
// - Beat counter is ADDR_WIDTH+$clog2(N_BANK)+1 bits; total = N_BANK*len.
// - len = 2^ADDR_WIDTH is legal: addr wraps from max to 0.
// STRUCTURE
// - Shared package dr_pkg: state enum {IDLE, READ, DRAIN, DONE}, $clog2 bank width.
// - One sub-module, dr_fifo2: 2-deep first-word-fall-through FIFO with cnt/full/empty.
// TESTING
// 1 N_BANK=4, len=3, tready=1 -> 12 beats, one per cycle.
//   mem_en/addr sequence (b0,a0)..(b3,a2); tlast only on beat 12; idle=1 after.
// 2 As 1, tready toggling 1,0,1,0 -> same 12 data in order.
//   tdata held during tready=0; no beat lost or duplicated.
// 3 len=0 start -> no mem_en, no tvalid; idle low for 2 cycles, then high.
// 4 start pulsed again while busy with len=5 -> ignored; transfer uses original len=3.
// 5 rst asserted after beat 5 while tready=0 -> next cycle tvalid=0, mem_en=0, idle=1.
//   A fresh start then gives the full 12 beats.
// 6 len=1, N_BANK=2, tready=0 for 10 cycles, then 1 ->
//   at most 2 reads issue before stall; both beats delivered, tlast on beat 2.

Source files
------------

// File: rtl/dr_pkg.sv
// Shared types for the data_reader result-memory drain path.
// Holds the controller state encoding and the bank-index width helper.
package dr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  function automatic int bankWidth(input int nBank);
    return (nBank > 1) ? $clog2(nBank) : 1;
  endfunction

endpackage

// File: rtl/dr_fifo2.sv
// Two-entry first-word-fall-through FIFO; the head entry is always visible on dout_o.
// Push and pop may coincide at any occupancy, including when full.
module dr_fifo2 #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [1:0]       cnt_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rdPtr_q;
  logic             wrPtr_q;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic             doPush;
  logic             doPop;

  assign doPop   = pop_i && (cnt_q != 2'd0);
  assign doPush  = push_i && ((cnt_q != 2'd2) || doPop);
  assign cnt_d   = cnt_q + {1'b0, doPush} - {1'b0, doPop};

  assign dout_o  = mem_q[rdPtr_q];
  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rdPtr_q  <= 1'b0;
      wrPtr_q  <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= din_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (doPop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/data_reader.sv
// Drains N_BANK result banks (len words each, bank-major order) into an AXIS master stream.
// Reads are issued only when the 2-entry output FIFO is guaranteed room for the returning word.
module data_reader
  import dr_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int N_BANK     = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH:0]          len,
  output logic                         idle,
  output logic [N_BANK-1:0]            mem_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [N_BANK*DATA_WIDTH-1:0] mem_do,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]      m_axis_tstrb,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready
);

  localparam int BW = bankWidth(N_BANK);
  localparam int CW = ADDR_WIDTH + BW + 1;

  state_e                state_q, state_d;
  logic [BW-1:0]         bank_q, bank_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [CW-1:0]         total_q, total_d;
  logic [CW-1:0]         issueCnt_q, issueCnt_d;
  logic                  inflight_q, inflight_d;
  logic [BW-1:0]         inflightBank_q, inflightBank_d;
  logic                  inflightLast_q, inflightLast_d;
  logic                  idle_q, idle_d;

  logic                  pop;
  logic                  issue;
  logic                  lastIssue;
  logic [N_BANK-1:0]     memEn;
  logic [DATA_WIDTH-1:0] rdData;
  logic [DATA_WIDTH:0]   fifoDout;
  logic [1:0]            fifoCnt;
  logic                  fifoFull;
  logic                  fifoEmpty;

  assign pop       = m_axis_tvalid && m_axis_tready;
  assign lastIssue = (issueCnt_q == total_q - CW'(1));
  // Occupancy after this edge (cnt + inflight - pop) must stay below 2; cnt=2 with a read in flight never occurs.
  assign issue     = (state_q == READ) &&
                     (pop || !(fifoFull || ((fifoCnt == 2'd1) && inflight_q)));

  always_comb begin
    rdData = '0;
    for (int b = 0; b < N_BANK; b++) begin
      if (inflightBank_q == BW'(b)) begin
        rdData = mem_do[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bank_d         = bank_q;
    addr_d         = addr_q;
    len_d          = len_q;
    total_d        = total_q;
    issueCnt_d     = issueCnt_q;
    inflight_d     = issue;
    inflightBank_d = bank_q;
    inflightLast_d = issue && lastIssue;
    memEn          = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d      = len;
          total_d    = CW'(len) * CW'(N_BANK);
          bank_d     = '0;
          addr_d     = '0;
          issueCnt_d = '0;
          state_d    = (len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue) begin
          memEn[bank_q] = 1'b1;
          issueCnt_d    = issueCnt_q + 1'b1;
          if ({1'b0, addr_q} == len_q - 1'b1) begin
            addr_d = '0;
            bank_d = bank_q + 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
          if (lastIssue) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifoEmpty && !inflight_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    idle_d = (state_q == IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      bank_q         <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      total_q        <= '0;
      issueCnt_q     <= '0;
      inflight_q     <= 1'b0;
      inflightBank_q <= '0;
      inflightLast_q <= 1'b0;
      idle_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      bank_q         <= bank_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      total_q        <= total_d;
      issueCnt_q     <= issueCnt_d;
      inflight_q     <= inflight_d;
      inflightBank_q <= inflightBank_d;
      inflightLast_q <= inflightLast_d;
      idle_q         <= idle_d;
    end
  end

  dr_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) uFifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (inflight_q),
    .din_i  ({inflightLast_q, rdData}),
    .pop_i  (pop),
    .dout_o (fifoDout),
    .cnt_o  (fifoCnt),
    .full_o (fifoFull),
    .empty_o(fifoEmpty)
  );

  assign idle          = idle_q;
  assign mem_en        = memEn;
  assign mem_addr      = addr_q;
  assign m_axis_tvalid = !fifoEmpty;
  assign m_axis_tlast  = fifoDout[DATA_WIDTH];
  assign m_axis_tdata  = fifoDout[DATA_WIDTH-1:0];
  assign m_axis_tstrb  = '1;

endmodule

// File: tb/tb_data_reader.sv
// Randomized bench for data_reader: a bank memory model plus queues of the expected
// read-issue order and beat stream, built directly from the bank-major drain order.
module tb_data_reader;

  localparam int DW = 32;
  localparam int NB = 4;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [AW:0]     lenIn = '0;
  logic            idle;
  logic [NB-1:0]   memEn;
  logic [AW-1:0]   memAddr;
  logic [NB*DW-1:0] memDo;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;
  logic            tlast;
  logic            tvalid;
  logic            tready = 1'b0;

  logic [DW-1:0] memArr [NB][1<<AW];
  logic [DW-1:0] memOut [NB];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int startCyc = 0;
  int readyMode = 0;
  int beatCount = 0;
  int issueCount = 0;
  int issueQ [$];
  logic [DW:0] beatQ [$];
  logic        prevHold = 1'b0;
  logic [DW:0] held = '0;
  int          monBank;
  int          monExp;
  logic [DW:0] monBeat;

  data_reader #(
    .DATA_WIDTH(DW),
    .N_BANK    (NB),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .len          (lenIn),
    .idle         (idle),
    .mem_en       (memEn),
    .mem_addr     (memAddr),
    .mem_do       (memDo),
    .m_axis_tdata (tdata),
    .m_axis_tstrb (tstrb),
    .m_axis_tlast (tlast),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready)
  );

  always #5 clk = ~clk;

  // Banks are synchronous-read RAMs: data for an enable in cycle t appears in cycle t+1.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (memEn[b]) memOut[b] <= memArr[b][memAddr];
    end
  end

  for (genvar g = 0; g < NB; g++) begin : gMemDo
    assign memDo[g*DW +: DW] = memOut[g];
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    case (readyMode)
      0: tready = 1'b1;
      1: tready = (((cyc - startCyc) % 2) == 0);
      2: tready = 1'($urandom_range(0, 1));
      3: tready = ((cyc - startCyc) >= 10);
      default: tready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prevHold = 1'b0;
    end else begin
      if (memEn != '0) begin
        monBank = 0;
        for (int b = 0; b < NB; b++) if (memEn[b]) monBank = b;
        checkOutput("memEnOneHot", 64'($onehot(memEn)), 64'd1);
        if (issueQ.size() == 0) begin
          checkOutput("unexpectedIssue", 64'd1, 64'd0);
        end else begin
          monExp = issueQ.pop_front();
          checkOutput("issueBankAddr", 64'(monBank * 16 + int'(memAddr)), 64'(monExp));
        end
        issueCount++;
      end
      if (prevHold) begin
        checkOutput("holdValid", 64'(tvalid), 64'd1);
        checkOutput("holdBeat", 64'({tlast, tdata}), 64'(held));
      end
      prevHold = tvalid && !tready;
      held = {tlast, tdata};
      if (tvalid && tready) begin
        if (beatQ.size() == 0) begin
          checkOutput("unexpectedBeat", 64'd1, 64'd0);
        end else begin
          monBeat = beatQ.pop_front();
          checkOutput("beat", 64'({tlast, tdata}), 64'(monBeat));
        end
        beatCount++;
      end
    end
  end

  task automatic buildModel(input int l);
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < (1 << AW); a++) memArr[b][a] = $urandom;
    end
    issueQ.delete();
    beatQ.delete();
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < l; a++) begin
        issueQ.push_back(b * 16 + a);
        beatQ.push_back({((b == NB - 1) && (a == l - 1)), memArr[b][a]});
      end
    end
    beatCount = 0;
    issueCount = 0;
  endtask

  task automatic applyStimulus(input int l, input int mode, input int restartAt);
    int k;
    int firstValid;
    int idleLow;
    buildModel(l);
    @(posedge clk); #1;
    readyMode = mode;
    startCyc = cyc;
    start = 1'b1;
    lenIn = (AW+1)'(l);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    firstValid = -1;
    idleLow = 0;
    while (k < 400) begin
      if (tvalid && firstValid < 0) firstValid = k;
      if (idle) break;
      idleLow++;
      if (mode == 3 && k == 6) checkOutput("stallIssues", 64'(issueCount), 64'd2);
      start = (k == restartAt);
      if (k == restartAt) lenIn = 5;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    if (k >= 400) checkOutput("idleTimeout", 64'd0, 64'd1);
    checkOutput("beatTotal", 64'(beatCount), 64'(NB * l));
    checkOutput("issueTotal", 64'(issueCount), 64'(NB * l));
    checkOutput("beatsLeft", 64'(beatQ.size()), 64'd0);
    checkOutput("firstValid", 64'(firstValid), 64'((l > 0) ? 2 : -1));
    if (l == 0) checkOutput("idleLowCycles", 64'(idleLow), 64'd2);
  endtask

  initial begin
    int n;
    for (int b = 0; b < NB; b++) memOut[b] = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstIdle", 64'(idle), 64'd1);
    checkOutput("rstMemEn", 64'(memEn), 64'd0);
    checkOutput("rstMemAddr", 64'(memAddr), 64'd0);
    checkOutput("rstValid", 64'(tvalid), 64'd0);
    checkOutput("rstLast", 64'(tlast), 64'd0);
    checkOutput("rstData", 64'(tdata), 64'd0);
    checkOutput("tstrb", 64'(tstrb), 64'hF);
    rst = 1'b0;

    $display("[TB] streaming, tready high");
    applyStimulus(3, 0, -1);
    $display("[TB] streaming, tready toggling");
    applyStimulus(3, 1, -1);
    $display("[TB] zero length");
    applyStimulus(0, 0, -1);
    $display("[TB] start while busy");
    applyStimulus(3, 0, 3);

    $display("[TB] reset mid-transfer");
    buildModel(3);
    @(posedge clk); #1;
    readyMode = 0;
    startCyc = cyc;
    start = 1'b1;
    lenIn = 3;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (beatCount < 5 && n < 100) begin
      @(posedge clk);
      n++;
    end
    readyMode = 4;
    if (n >= 100) checkOutput("beat5Timeout", 64'd0, 64'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstBeats", 64'(beatCount), 64'd5);
    checkOutput("midRstValid", 64'(tvalid), 64'd0);
    checkOutput("midRstMemEn", 64'(memEn), 64'd0);
    checkOutput("midRstIdle", 64'(idle), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(3, 0, -1);

    $display("[TB] stalled sink, len 1");
    applyStimulus(1, 3, -1);
    $display("[TB] full-depth banks, random tready");
    applyStimulus(1 << AW, 2, -1);
    $display("[TB] random lengths");
    repeat (4) applyStimulus(int'($urandom_range(1, 1 << AW)), 2, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
